hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller. It consumes the fields the ID/EX register publishes (rs/rt/rd, mem_read, reg_write),
//  together with the ID-stage sources and the EX/MEM and MEM/WB destinations.
//  It drives stall/flush back into PC, IF/ID and ID/EX, and drives the EX forwarding selects.
//  A registered FSM tracks load-use bubbles, control redirects and data-memory freezes.
// PARAMETERS
//  REG_ADDR_W    5    register index width
//  FREEZE_LIMIT  255  FREEZE cycles before freeze_timeout sets
//  CNT_W         32   perf counter width
// PORTS
//  clk              in   1   rising-edge clock
//  reset_n          in   1   asynchronous, active-low reset
//  id_rs1,id_rs2    in   5   source regs of instr in ID
//  id_use_rs1/rs2   in   1   instr in ID actually reads rs1/rs2
//  idex_rs1,idex_rs2 in  5   ID/EX rs_out/rt_out
//  idex_rd          in   5   ID/EX rd_out
//  idex_mem_read    in   1   ID/EX holds a load
//  exmem_rd / exmem_reg_write  in 5/1  EX/MEM destination, write-enable
//  memwb_rd / memwb_reg_write  in 5/1  MEM/WB destination, write-enable
//  ex_redirect      in   1   taken branch/jump resolved in EX this cycle
//  dmem_busy        in   1   data memory wait request
//  pc_stall, ifid_stall        out 1  hold PC / IF/ID
//  ifid_flush, idex_flush      out 1  load bubble into IF/ID / ID/EX
//  pipe_freeze      out  1   hold every pipeline register
//  fwd_a, fwd_b     out  2   00 regfile, 01 MEM/WB, 10 EX/MEM
//  hz_state         out  2   current FSM state
//  freeze_timeout   out  1   sticky watchdog flag
//  stall_cycles, flush_events  out CNT_W  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n low, async): state=RUN, freeze_timeout=0, counters=0; all stall/flush/freeze outputs 0.
//  Control outputs: combinational from registered state plus current inputs. Zero added latency.
//  load_use = idex_mem_read & idex_rd!=0 & ((use_rs1 & idex_rd==id_rs1) | (use_rs2 & idex_rd==id_rs2)).
//  Priority, evaluated in RUN/LU_STALL/FLUSH:
//   dmem_busy > ex_redirect > load_use.
//  RUN:
//   dmem_busy -> FREEZE; outputs pc_stall=ifid_stall=pipe_freeze=1 same cycle.
//   ex_redirect -> FLUSH; ifid_flush=idex_flush=1, pc_stall=0.
//   load_use -> LU_STALL; pc_stall=ifid_stall=idex_flush=1.
//   else stay RUN, all 0.
//  LU_STALL, FLUSH: one-cycle states.
//   load_use detection is suppressed (ID/EX holds a bubble).
//   dmem_busy/ex_redirect are still honoured as in RUN; otherwise -> RUN.
//  FREEZE: pipe_freeze=pc_stall=ifid_stall=1, flushes 0.
//   Counter increments each cycle.
//   dmem_busy low -> RUN (no output pulse that cycle); counter cleared.
//   Counter reaching FREEZE_LIMIT sets freeze_timeout (sticky until reset); state stays FREEZE.
//   ex_redirect is ignored while frozen; EX holds it and it is taken on the cycle after exit.
//  Forwarding (combinational, every cycle, independent of state):
//   fwd_a=10 if exmem_reg_write & exmem_rd!=0 & exmem_rd==idex_rs1;
//   else 01 if the same test passes on memwb; else 00. fwd_b is identical using idex_rs2.
//   EX/MEM wins over MEM/WB. x0 is never forwarded.
//  Reset asserted mid-state: immediate return to RUN, outputs 0, no residual stall.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   stall_cycles counts cycles with pc_stall=1.
//   flush_events counts ex_redirect acceptances.
//   Both saturate at all-ones and are cleared by reset.
//  HAZARD_PERF_EN undefined: no counter logic; ports remain and are tied to 0.
// STRUCTURE
//  hazard_pkg:
//   enum hz_state_e {HZ_RUN=0, HZ_LU_STALL=1, HZ_FLUSH=2, HZ_FREEZE=3};
//   enum fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
//   REG_ADDR_W constant.
//  Sub-module fwd_sel_unit: one operand's forwarding compare, instantiated twice (A, B).
// TESTING
//  1 idex_mem_read=1, idex_rd=5, id_rs1=5, use_rs1=1
//    -> same cycle pc_stall=ifid_stall=idex_flush=1; next cycle hz_state=LU_STALL, all 0.
//  2 idex_mem_read=1, idex_rd=0, id_rs1=0 -> no stall, state stays RUN.
//  3 exmem_rd=memwb_rd=7, both write=1, idex_rs1=7 -> fwd_a=10;
//    drop exmem_reg_write -> fwd_a=01; set exmem_rd=0 -> fwd_a=01.
//  4 ex_redirect and load_use in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0, next state FLUSH.
//  5 FREEZE_LIMIT=4, dmem_busy held 6 cycles -> pipe_freeze=1 throughout;
//    freeze_timeout=1 after 4th cycle and stays 1 after exit.
//  6 reset_n low mid-FREEZE -> hz_state=RUN, all controls 0 asynchronously;
//    with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Included by hazard_ctrl and fwd_sel_unit.
package hazard_pkg;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_FREEZE   = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one EX operand.
// EX/MEM result wins over MEM/WB; x0 is never forwarded.
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_ex_rd,
  input  logic          i_ex_we,
  input  logic [AW-1:0] i_wb_rd,
  input  logic          i_wb_we,
  output fwd_sel_e      o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_we && i_ex_rd != '0 && i_ex_rd == i_rs)
      o_sel = FWD_MEM;
    else if (i_wb_we && i_wb_rd != '0 && i_wb_rd == i_rs)
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect, dmem freeze, forwarding.
// Define HAZARD_PERF_EN to build the stall/flush perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = hazard_pkg::REG_ADDR_W,
  parameter int FREEZE_LIMIT = 255,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rs1,
  input  logic [REG_ADDR_W-1:0] idex_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic                  ex_redirect,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  pipe_freeze,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            hz_state,
  output logic                  freeze_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int FW = $clog2(FREEZE_LIMIT + 1);

  hz_state_e r_state;
  hz_state_e w_nxt;
  logic [FW-1:0] r_fcnt;
  logic r_timeout;
  logic w_lu;
  logic w_pc_stall, w_ifid_stall, w_ifid_flush;
  logic w_idex_flush, w_freeze;
  fwd_sel_e w_fwd_a, w_fwd_b;

  assign w_lu = idex_mem_read && idex_rd != '0 &&
                ((id_use_rs1 && idex_rd == id_rs1) ||
                 (id_use_rs2 && idex_rd == id_rs2));

  always_comb begin
    w_nxt        = HZ_RUN;
    w_pc_stall   = 1'b0;
    w_ifid_stall = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_freeze     = 1'b0;
    unique case (r_state)
      HZ_FREEZE: begin
        if (dmem_busy) begin
          w_nxt        = HZ_FREEZE;
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_freeze     = 1'b1;
        end
      end
      default: begin
        // load-use is masked after a bubble/flush: ID/EX is empty
        if (dmem_busy) begin
          w_nxt        = HZ_FREEZE;
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_freeze     = 1'b1;
        end else if (ex_redirect) begin
          w_nxt        = HZ_FLUSH;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (w_lu && r_state == HZ_RUN) begin
          w_nxt        = HZ_LU_STALL;
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_idex_flush = 1'b1;
        end
      end
    endcase
    if (!reset_n) begin
      w_pc_stall   = 1'b0;
      w_ifid_stall = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_freeze     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= HZ_RUN;
      r_fcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == HZ_FREEZE) begin
        if (!dmem_busy) begin
          r_fcnt <= '0;
        end else if (r_fcnt != FW'(FREEZE_LIMIT)) begin
          r_fcnt <= r_fcnt + FW'(1);
          if (r_fcnt == FW'(FREEZE_LIMIT - 1))
            r_timeout <= 1'b1;
        end
      end
    end
  end

  fwd_sel_unit #(.AW(REG_ADDR_W)) u_fwd_a (
    .i_rs    (idex_rs1),
    .i_ex_rd (exmem_rd),
    .i_ex_we (exmem_reg_write),
    .i_wb_rd (memwb_rd),
    .i_wb_we (memwb_reg_write),
    .o_sel   (w_fwd_a)
  );

  fwd_sel_unit #(.AW(REG_ADDR_W)) u_fwd_b (
    .i_rs    (idex_rs2),
    .i_ex_rd (exmem_rd),
    .i_ex_we (exmem_reg_write),
    .i_wb_rd (memwb_rd),
    .i_wb_we (memwb_reg_write),
    .o_sel   (w_fwd_b)
  );

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic w_redir_acc;

  assign w_redir_acc = ex_redirect && !dmem_busy &&
                       r_state != HZ_FREEZE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redir_acc && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

  assign pc_stall       = w_pc_stall;
  assign ifid_stall     = w_ifid_stall;
  assign ifid_flush     = w_ifid_flush;
  assign idex_flush     = w_idex_flush;
  assign pipe_freeze    = w_freeze;
  assign fwd_a          = w_fwd_a;
  assign fwd_b          = w_fwd_b;
  assign hz_state       = r_state;
  assign freeze_timeout = r_timeout;

endmodule
